// File: rtl/io_map_pkg.sv
// Address map for the 0x8xxx_xxxx I/O region: region tag plus register offsets.
package io_map_pkg;

  localparam logic [3:0]  IO_REGION = 4'b1000;

  localparam logic [27:0] RX_STAT  = 28'h000_0000;
  localparam logic [27:0] RX_DATA  = 28'h000_0004;
  localparam logic [27:0] TX_STAT  = 28'h000_0008;
  localparam logic [27:0] TX_DATA  = 28'h000_000C;
  localparam logic [27:0] CYC_CNT  = 28'h000_0010;
  localparam logic [27:0] INST_CNT = 28'h000_0014;
  localparam logic [27:0] CNT_RST  = 28'h000_0018;

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO with occupancy count; push when full and pop when
// empty are ignored internally so callers may request them freely.
module sync_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally at DEPTH; count only moves when exactly one side fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_mmio_fifo.sv
// MMIO bridge between the CPU I/O path and the UART: RX/TX FIFOs, status
// registers and cycle/retired-instruction counters with a 1-cycle load path.
module uart_mmio_fifo
  import io_map_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] io_addr,
  input  logic        io_re,
  input  logic        io_we,
  input  logic [7:0]  io_wdata,
  input  logic        inst_retire,
  output logic [31:0] io_rdata,
  output logic [7:0]  uart_din,
  output logic        uart_din_valid,
  input  logic        uart_din_ready,
  input  logic [7:0]  uart_dout,
  input  logic        uart_dout_valid,
  output logic        uart_dout_ready
);

  logic                in_region;
  logic [27:0]         offset;
  logic                rd_en;
  logic                wr_en;
  logic                rx_pop;
  logic                tx_push;
  logic                tx_pop;
  logic                cnt_clr;
  logic [7:0]          rx_head;
  logic [7:0]          tx_head;
  logic                rx_full, rx_empty, tx_full, tx_empty;
  logic [DEPTH_LOG2:0] rx_count, tx_count;
  logic [31:0]         cycle_cnt;
  logic [31:0]         instr_cnt;
  logic [31:0]         rd_sel;

  assign in_region = (io_addr[31:28] == IO_REGION);
  assign offset    = io_addr[27:0];
  // A store that coincides with a load is ignored; the CPU never issues both.
  assign rd_en     = in_region && io_re && !stall;
  assign wr_en     = in_region && io_we && !io_re && !stall;
  assign rx_pop    = rd_en && (offset == RX_DATA);
  assign tx_push   = wr_en && (offset == TX_DATA);
  assign cnt_clr   = wr_en && (offset == CNT_RST);

  assign uart_dout_ready = !rx_full;
  assign uart_din_valid  = !tx_empty;
  assign uart_din        = tx_empty ? 8'd0 : tx_head;
  assign tx_pop          = uart_din_valid && uart_din_ready;

  sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (uart_dout_valid && uart_dout_ready),
    .pop   (rx_pop),
    .din   (uart_dout),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (io_wdata),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  always_comb begin
    rd_sel = '0;
    case (offset)
      RX_STAT:  rd_sel = (32'(rx_count) << 8) | 32'(!rx_empty);
      RX_DATA:  rd_sel = rx_empty ? 32'd0 : {24'd0, rx_head};
      TX_STAT:  rd_sel = (32'(tx_count) << 8) | 32'(!tx_full);
      CYC_CNT:  rd_sel = cycle_cnt;
      INST_CNT: rd_sel = instr_cnt;
      default:  rd_sel = '0;
    endcase
  end

  // Load data is held across stalls and cleared on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_rdata <= '0;
    end else if (!stall) begin
      io_rdata <= rd_en ? rd_sel : 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (cnt_clr) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (inst_retire && !stall) instr_cnt <= instr_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed scoreboard bench for uart_mmio_fifo: RX/TX queues model FIFO contents,
// constants give register and counter values.
module tb_uart_mmio_fifo;

  localparam logic [31:0] A_RX_STAT  = 32'h8000_0000;
  localparam logic [31:0] A_RX_DATA  = 32'h8000_0004;
  localparam logic [31:0] A_TX_STAT  = 32'h8000_0008;
  localparam logic [31:0] A_TX_DATA  = 32'h8000_000C;
  localparam logic [31:0] A_CYC      = 32'h8000_0010;
  localparam logic [31:0] A_INST     = 32'h8000_0014;
  localparam logic [31:0] A_CNT_RST  = 32'h8000_0018;
  localparam int          DEPTH      = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] io_addr;
  logic        io_re;
  logic        io_we;
  logic [7:0]  io_wdata;
  logic        inst_retire;
  logic [31:0] io_rdata;
  logic [7:0]  uart_din;
  logic        uart_din_valid;
  logic        uart_din_ready;
  logic [7:0]  uart_dout;
  logic        uart_dout_valid;
  logic        uart_dout_ready;

  int checks = 0;
  int failures = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  uart_mmio_fifo #(.DEPTH_LOG2(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .io_addr         (io_addr),
    .io_re           (io_re),
    .io_we           (io_we),
    .io_wdata        (io_wdata),
    .inst_retire     (inst_retire),
    .io_rdata        (io_rdata),
    .uart_din        (uart_din),
    .uart_din_valid  (uart_din_valid),
    .uart_din_ready  (uart_din_ready),
    .uart_dout       (uart_dout),
    .uart_dout_valid (uart_dout_valid),
    .uart_dout_ready (uart_dout_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One CPU-side access lasting a single cycle.
  task automatic applyStimulus(input logic [31:0] addr, input logic re, input logic we,
                               input logic [7:0] wdata);
    io_addr  = addr;
    io_re    = re;
    io_we    = we;
    io_wdata = wdata;
    tick();
    io_re = 1'b0;
    io_we = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    applyStimulus(addr, 1'b1, 1'b0, 8'h00);
    checkOutput(tag, io_rdata, exp);
  endtask

  task automatic rx_read(input string tag);
    logic [31:0] exp;
    exp = (rx_q.size() > 0) ? {24'd0, rx_q.pop_front()} : 32'd0;
    read_check(tag, A_RX_DATA, exp);
  endtask

  task automatic tx_write(input logic [7:0] b);
    if (tx_q.size() < DEPTH) tx_q.push_back(b);
    applyStimulus(A_TX_DATA, 1'b0, 1'b1, b);
  endtask

  task automatic uart_send(input logic [7:0] b);
    checkOutput("rx_ready", {31'd0, uart_dout_ready}, {31'd0, rx_q.size() < DEPTH});
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    uart_dout       = b;
    uart_dout_valid = 1'b1;
    tick();
    uart_dout_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; io_addr = '0; io_re = 1'b0; io_we = 1'b0;
    io_wdata = '0; inst_retire = 1'b0; uart_din_ready = 1'b0;
    uart_dout = '0; uart_dout_valid = 1'b0;
    #2;
    checkOutput("rst_din_valid", {31'd0, uart_din_valid}, 32'd0);
    checkOutput("rst_din", {24'd0, uart_din}, 32'd0);
    checkOutput("rst_rdata", io_rdata, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_dout_ready", {31'd0, uart_dout_ready}, 32'd1);

    // RX basic
    uart_send(8'h41);
    uart_send(8'h42);
    read_check("rx_stat_two", A_RX_STAT, 32'h0000_0201);
    rx_read("rx_data_a");
    rx_read("rx_data_b");
    read_check("rx_stat_empty", A_RX_STAT, 32'h0000_0000);
    rx_read("rx_data_empty");

    // RX overflow
    for (int i = 0; i < 9; i++) uart_send(8'(i));
    read_check("rx_stat_full", A_RX_STAT, 32'h0000_0801);
    rx_read("rx_ovf_0");
    checkOutput("rx_ready_after_pop", {31'd0, uart_dout_ready}, 32'd1);
    for (int i = 1; i < 8; i++) rx_read($sformatf("rx_ovf_%0d", i));
    read_check("rx_stat_drained", A_RX_STAT, 32'h0000_0000);

    // TX backpressure
    uart_din_ready = 1'b0;
    for (int i = 0; i < 8; i++) tx_write(8'h10 + 8'(i));
    read_check("tx_stat_full", A_TX_STAT, 32'h0000_0800);
    tx_write(8'h18);
    read_check("tx_stat_dropped", A_TX_STAT, 32'h0000_0800);
    applyStimulus(32'h4000_000C, 1'b0, 1'b1, 8'hEE);
    read_check("tx_stat_offregion", A_TX_STAT, 32'h0000_0800);
    checkOutput("tx_valid_full", {31'd0, uart_din_valid}, 32'd1);
    // Drain and a write to the full FIFO land on the same edge: write dropped.
    checkOutput("tx_drain_0", {24'd0, uart_din}, {24'd0, tx_q.pop_front()});
    uart_din_ready = 1'b1;
    applyStimulus(A_TX_DATA, 1'b0, 1'b1, 8'h99);
    for (int i = 1; i < 8; i++) begin
      checkOutput($sformatf("tx_drain_%0d", i), {24'd0, uart_din}, {24'd0, tx_q.pop_front()});
      tick();
    end
    checkOutput("tx_valid_empty", {31'd0, uart_din_valid}, 32'd0);
    uart_din_ready = 1'b0;

    // Stall during RX-data read
    uart_send(8'h55);
    read_check("stall_stat_pre", A_RX_STAT, 32'h0000_0101);
    io_addr = A_RX_DATA; io_re = 1'b1; stall = 1'b1;
    tick();
    checkOutput("stall_hold_1", io_rdata, 32'h0000_0101);
    tick();
    checkOutput("stall_hold_2", io_rdata, 32'h0000_0101);
    stall = 1'b0;
    rx_read("stall_rx_data");
    read_check("stall_stat_post", A_RX_STAT, 32'h0000_0000);
    read_check("unmapped_read", 32'h8000_001C, 32'h0000_0000);
    read_check("cnt_rst_read", A_CNT_RST, 32'h0000_0000);

    // Counters from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rx_q.delete();
    tx_q.delete();
    for (int i = 0; i < 100; i++) begin
      inst_retire = (i < 40);
      tick();
    end
    inst_retire = 1'b0;
    read_check("cycle_cnt_100", A_CYC, 32'd100);
    read_check("instr_cnt_40", A_INST, 32'd40);
    tick();
    checkOutput("rdata_idle_zero", io_rdata, 32'd0);
    read_check("offregion_read", 32'h4000_0010, 32'd0);

    inst_retire = 1'b1;
    applyStimulus(A_CNT_RST, 1'b0, 1'b1, 8'h00);
    tick();
    tick();
    tick();
    inst_retire = 1'b0;
    read_check("instr_after_clr", A_INST, 32'd3);
    read_check("cycle_after_clr", A_CYC, 32'd4);
    stall = 1'b1; inst_retire = 1'b1;
    tick();
    stall = 1'b0; inst_retire = 1'b0;
    read_check("instr_stalled", A_INST, 32'd3);

    // Async reset mid-drain
    uart_din_ready = 1'b0;
    tx_write(8'hA1);
    tx_write(8'hA2);
    tx_write(8'hA3);
    checkOutput("mid_valid", {31'd0, uart_din_valid}, 32'd1);
    checkOutput("mid_din", {24'd0, uart_din}, {24'd0, tx_q[0]});
    uart_din_ready = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_din_valid", {31'd0, uart_din_valid}, 32'd0);
    checkOutput("async_din", {24'd0, uart_din}, 32'd0);
    checkOutput("async_rdata", io_rdata, 32'd0);
    tx_q.delete();
    tick();
    rst = 1'b0;
    uart_din_ready = 1'b0;
    read_check("post_rst_rx_stat", A_RX_STAT, 32'h0000_0000);
    read_check("post_rst_tx_stat", A_TX_STAT, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
